deserializer_mod: RTL and testbench
===================================

Name: deserializer_mod

Overview:
- Downstream stage of the team's serializer: consumes the MSB-first serial stream (ser_data / ser_data_val) and reassembles parallel words.
- Each contiguous valid burst becomes one word, plus the number of bits received.
- Emits a one-cycle valid pulse per word.
- Sits between the serial link and the parallel consumer. There is no backpressure; the consumer must accept every pulse.

Parameters:
- WIDTH, 8: output word width; maximum bits per word.
- MOD_BITS, $clog2(WIDTH)+1: width of the bit-count output; must hold the value WIDTH.
- MIN_BITS, 3: minimum burst length accepted; shorter bursts are discarded.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- ser_data_i  input  1  serial data bit, MSB first.
- ser_data_val_i  input  1  ser_data_i is valid this cycle.
- deser_data_o  output  WIDTH  reassembled word, left-justified; unreceived LSBs are 0.
- deser_mod_o  output  MOD_BITS  number of bits in the word, MIN_BITS..WIDTH.
- deser_data_val_o  output  1  one-cycle pulse; deser_data_o and deser_mod_o are valid.
- busy_o  output  1  high while a burst is being collected.

Behaviour:
- Reset:
  - arst_n_i low clears all state immediately, without waiting for a clock edge.
  - All outputs go to 0, bit counter 0, shift register 0, state IDLE.
  - Reset asserted mid-burst drops the partial word; no pulse is emitted.
- States:
  - IDLE: no partial word.
  - COLLECT: cnt bits held, 1 <= cnt < WIDTH.
- Bit capture:
  - On each cycle with ser_data_val_i=1, the bit is written to shift[WIDTH-1-cnt] and cnt increments.
  - A bit arriving in IDLE goes to shift[WIDTH-1], sets cnt=1 and moves to COLLECT.
- Burst end: the first cycle with ser_data_val_i=0 while in COLLECT.
  - If cnt >= MIN_BITS: next cycle deser_data_val_o=1, deser_data_o=shift, deser_mod_o=cnt.
  - If cnt < MIN_BITS: burst discarded, no pulse.
  - In both cases: state returns to IDLE, shift and cnt clear.
- Full word:
  - When the captured bit makes cnt=WIDTH, the word is emitted the next cycle with deser_mod_o=WIDTH.
  - State returns to IDLE in the same edge, so a valid bit on the very next cycle starts a new word (back-to-back, no gap needed).
- Latency: one clock from the burst-terminating event (val falling, or the WIDTH-th bit) to the pulse.
- Output hold:
  - deser_data_o and deser_mod_o are registered and hold their last emitted value until the next pulse.
  - deser_data_val_o is high for exactly one cycle per word.
- busy_o: 1 in COLLECT, 0 in IDLE, registered.
- Idle behaviour: ser_data_i is ignored when ser_data_val_i=0.
- Counter width: cnt is MOD_BITS wide; it never exceeds WIDTH.

Optional Feature:
- Macro: DESER_SHORT_ERR_EN.
- Defined:
  - Adds port short_err_o (output, 1), a one-cycle pulse, coincident in timing with where deser_data_val_o would have fired, for every discarded short burst.
  - Adds port short_err_cnt_o (output, 8), a saturating count of discarded bursts that stops at 255. Reset value 0.
- Undefined: neither port exists; short bursts are silently discarded; the rest of the behaviour is identical.

Decomposition:
- Package deser_pkg: state enum (IDLE, COLLECT), and a function computing MOD_BITS from WIDTH.
- Sub-module bit_counter_sat: a generic saturating counter.
  - Instantiated for short_err_cnt_o only under DESER_SHORT_ERR_EN.
  - Shift and capture logic stay in the top module.

Test Plan:
1. Reset then idle: assert arst_n_i=0 mid-cycle -> all outputs 0 immediately; 20 idle cycles after release -> no pulse, busy_o=0.
2. 5-bit burst 1,0,1,1,0 then val low -> one cycle later deser_data_val_o=1, deser_data_o=8'b10110000, deser_mod_o=5; busy_o high for cycles 2..6 relative to the first bit.
3. Full word 8'hA5 as 8 contiguous bits, followed immediately by a 3-bit burst 1,1,1 -> two pulses:
   - 8'hA5 with mod=8;
   - 8'b11100000 with mod=3.
4. 2-bit burst 1,1 -> no deser_data_val_o. With DESER_SHORT_ERR_EN: short_err_o pulses once, short_err_cnt_o=1.
5. Reset mid-burst: 4 bits sent, arst_n_i pulsed low, then val low -> no pulse; a following 3-bit burst 0,1,0 yields 8'b01000000, mod=3.
6. Round-trip with the serializer: data_i=8'hC3 for each data_mod_i from 3 to 7 -> deser_data_o equals the top data_mod_i bits of 8'hC3 with the rest zero, and deser_mod_o equals data_mod_i for every case.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Bit-count width able to represent the value WIDTH itself.
  function automatic int mod_bits_f(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_counter_sat.sv
// Generic up-counter that holds at its all-ones value instead of wrapping.
module bit_counter_sat #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/deserializer_mod.sv
// Reassembles MSB-first serial bursts into left-justified parallel words.
// Optional DESER_SHORT_ERR_EN adds a pulse and saturating count for discarded short bursts.
module deserializer_mod
  import deser_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MOD_BITS = mod_bits_f(WIDTH),
  parameter int MIN_BITS = 3
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                ser_data_i,
  input  logic                ser_data_val_i,
  output logic [WIDTH-1:0]    deser_data_o,
  output logic [MOD_BITS-1:0] deser_mod_o,
  output logic                deser_data_val_o,
`ifdef DESER_SHORT_ERR_EN
  output logic                short_err_o,
  output logic [7:0]          short_err_cnt_o,
`endif
  output logic                busy_o
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d, shift_new;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [MOD_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MOD_BITS-1:0] mod_q, mod_d;
  logic                val_q, val_d;

  // Unwritten shift bits are always zero, so OR-ing the positioned bit is enough.
  assign shift_new = shift_q | ({ser_data_i, {(WIDTH-1){1'b0}}} >> cnt_q);
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    if (ser_data_val_i) begin
      if (cnt_inc == MOD_BITS'(WIDTH)) begin
        data_d  = shift_new;
        mod_d   = MOD_BITS'(WIDTH);
        val_d   = 1'b1;
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        state_d = COLLECT;
        shift_d = shift_new;
        cnt_d   = cnt_inc;
      end
    end else if (state_q == COLLECT) begin
      if (cnt_q >= MOD_BITS'(MIN_BITS)) begin
        data_d = shift_q;
        mod_d  = cnt_q;
        val_d  = 1'b1;
      end
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_mod_o      = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = (state_q == COLLECT);

`ifdef DESER_SHORT_ERR_EN
  logic short_end, short_q;

  // Fires on the same edge that would have launched a word pulse.
  assign short_end = !ser_data_val_i && (state_q == COLLECT) &&
                     (cnt_q < MOD_BITS'(MIN_BITS));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      short_q <= 1'b0;
    end else begin
      short_q <= short_end;
    end
  end

  bit_counter_sat #(.W(8)) u_short_cnt (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .inc_i    (short_end),
    .cnt_o    (short_err_cnt_o)
  );

  assign short_err_o = short_q;
`endif

endmodule

// File: tb/tb_deserializer_mod.sv
// Self-checking bench for deserializer_mod against a queue-based burst model.
module tb_deserializer_mod;
  localparam int WIDTH    = 8;
  localparam int MIN_BITS = 3;

  logic       clk, arst_n, ser_data, ser_val;
  logic [7:0] deser_data;
  logic [3:0] deser_mod;
  logic       deser_val, busy;
`ifdef DESER_SHORT_ERR_EN
  logic       short_err;
  logic [7:0] short_err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
    logic [3:0]  mod;
  } word_t;

  word_t       obs_q[$], exp_q[$];
  int unsigned obs_short_q[$], exp_short_q[$];
  bit          m_bits[$];
  logic [7:0]  m_last_data = '0;
  logic [3:0]  m_last_mod = '0;
  int          m_short_cnt = 0;
  logic        m_busy = 1'b0;

  deserializer_mod dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (deser_data),
    .deser_mod_o      (deser_mod),
    .deser_data_val_o (deser_val),
`ifdef DESER_SHORT_ERR_EN
    .short_err_o      (short_err),
    .short_err_cnt_o  (short_err_cnt),
`endif
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (deser_val === 1'b1) obs_q.push_back({cyc, deser_data, deser_mod});
`ifdef DESER_SHORT_ERR_EN
    if (short_err === 1'b1) obs_short_q.push_back(cyc);
`endif
  end

  // Model: a burst is the list of bits seen; it becomes a word when it reaches
  // WIDTH bits or when valid drops with at least MIN_BITS bits collected.
  task automatic model_emit();
    logic [7:0] w;
    w = '0;
    foreach (m_bits[i]) w[WIDTH-1-i] = m_bits[i];
    exp_q.push_back({cyc + 1, w, 4'(m_bits.size())});
    m_last_data = w;
    m_last_mod  = 4'(m_bits.size());
    m_bits.delete();
  endtask

  task automatic drive_cycle(input logic v, input logic d);
    ser_val  = v;
    ser_data = v ? d : 1'($urandom_range(0, 1));
    if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() == WIDTH) model_emit();
    end else if (m_bits.size() != 0) begin
      if (m_bits.size() >= MIN_BITS) model_emit();
      else begin
        exp_short_q.push_back(cyc + 1);
        if (m_short_cnt < 255) m_short_cnt++;
        m_bits.delete();
      end
    end
    m_busy = (m_bits.size() != 0);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    ser_val = 1'b0;
    #2 arst_n = 1'b0;
    m_bits.delete();
    m_last_data = '0;
    m_last_mod  = '0;
    m_short_cnt = 0;
    m_busy      = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic flush();
    obs_q.delete(); exp_q.delete();
    obs_short_q.delete(); exp_short_q.delete();
  endtask

  task automatic test_reset();
    flush();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1);
    ser_val = 1'b0;
    #1;
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL rst_preword actual_n=%0d required=%h", obs_q.size(), exp_q[0]);
    end
    assert_reset();
    checks++;
    if ({deser_data, deser_mod, deser_val, busy} !== 14'd0) begin
      failures++;
      $display("FAIL rst_async actual data=%h mod=%0d val=%b busy=%b required all 0",
               deser_data, deser_mod, deser_val, busy);
    end
`ifdef DESER_SHORT_ERR_EN
    checks++;
    if ({short_err, short_err_cnt} !== 9'd0) begin
      failures++;
      $display("FAIL rst_short actual err=%b cnt=%0d required 0", short_err, short_err_cnt);
    end
`endif
    release_reset();
    flush();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || deser_val !== 1'b0 || deser_data !== 8'h00 || deser_mod !== 4'd0) begin
        failures++;
        $display("FAIL rst_idle cyc=%0d actual busy=%b val=%b data=%h mod=%0d required 0",
                 i, busy, deser_val, deser_data, deser_mod);
      end
    end
  endtask

  task automatic test_burst5();
    logic [4:0] pat;
    flush();
    pat = 5'b10110;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b5_busy_pre actual=%b required=0", busy); end
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive_cycle(1'b1, pat[4-i]); else drive_cycle(1'b0, 1'b1);
      checks++;
      if (busy !== (i < 5) || busy !== m_busy) begin
        failures++;
        $display("FAIL b5_busy step=%0d actual=%b required=%b", i, busy, (i < 5));
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL b5_count actual=%0d required=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== 8'b10110000 || obs_q[0].mod !== 4'd5 || obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL b5_word actual=%h required=%h", obs_q[0], exp_q[0]);
      end
    end
    checks++;
    if (deser_data !== 8'b10110000 || deser_mod !== 4'd5) begin
      failures++;
      $display("FAIL b5_hold actual data=%h mod=%0d required data=b0 mod=5", deser_data, deser_mod);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    flush();
    w = 8'hA5;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, w[7-i]);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count actual=%0d required=2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== 8'hA5 || obs_q[0].mod !== 4'd8 || obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b_word0 actual=%h required=%h", obs_q[0], exp_q[0]);
      end
      checks++;
      if (obs_q[1].data !== 8'b11100000 || obs_q[1].mod !== 4'd3 || obs_q[1] !== exp_q[1]) begin
        failures++;
        $display("FAIL b2b_word1 actual=%h required=%h", obs_q[1], exp_q[1]);
      end
    end
  endtask

  task automatic test_short();
    flush();
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL short_nopulse actual=%0d required=0", obs_q.size());
    end
`ifdef DESER_SHORT_ERR_EN
    checks++;
    if (obs_short_q.size() != 1 || exp_short_q.size() != 1 || obs_short_q[0] != exp_short_q[0]) begin
      failures++;
      $display("FAIL short_pulse actual_n=%0d required_n=1", obs_short_q.size());
    end
    checks++;
    if (short_err_cnt !== 8'd1 || short_err_cnt !== 8'(m_short_cnt)) begin
      failures++;
      $display("FAIL short_cnt actual=%0d required=1", short_err_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    flush();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1);
    assert_reset();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy actual=%b required=0", busy); end
    release_reset();
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL mr_count actual=%0d required=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].data !== 8'b01000000 || obs_q[0].mod !== 4'd3 || obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL mr_word actual=%h required=%h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [7:0] src, want;
    flush();
    src = 8'hC3;
    for (int m = 3; m <= 7; m++) begin
      for (int i = 0; i < m; i++) drive_cycle(1'b1, src[7-i]);
      drive_cycle(1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0);
    end
    drive_cycle(1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 5 || exp_q.size() != 5) begin
      failures++;
      $display("FAIL rt_count actual=%0d required=5", obs_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        want = src & ~(8'hFF >> (k + 3));
        checks++;
        if (obs_q[k].data !== want || obs_q[k].mod !== 4'(k + 3) || obs_q[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL rt_mod%0d actual data=%h mod=%0d required data=%h mod=%0d",
                   k + 3, obs_q[k].data, obs_q[k].mod, want, k + 3);
        end
      end
    end
  endtask

  task automatic test_random();
    int bad;
    flush();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      drive_cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      checks++;
      if (busy !== m_busy || deser_data !== m_last_data || deser_mod !== m_last_mod) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL rnd_state cyc=%0d actual busy=%b data=%h mod=%0d required busy=%b data=%h mod=%0d",
                   i, busy, deser_data, deser_mod, m_busy, m_last_data, m_last_mod);
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rnd_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          if (bad++ < 10) $display("FAIL rnd_word%0d actual=%h required=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
`ifdef DESER_SHORT_ERR_EN
    checks++;
    if (obs_short_q != exp_short_q || short_err_cnt !== 8'(m_short_cnt)) begin
      failures++;
      $display("FAIL rnd_short actual_n=%0d cnt=%0d required_n=%0d cnt=%0d",
               obs_short_q.size(), short_err_cnt, exp_short_q.size(), m_short_cnt);
    end
`endif
  endtask

  initial begin
    arst_n   = 1'b0;
    ser_val  = 1'b0;
    ser_data = 1'b0;
    #12 arst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_burst5();
    test_back_to_back();
    test_short();
    test_mid_reset();
    test_roundtrip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
